// File: rtl/dma_pkg.sv
// Shared types and defaults for the DMA receive path (controller, buffer, read engine).
package dma_pkg;

  localparam int unsigned DmaWidth = 8;
  localparam int unsigned DmaDepth = 8;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } rx_ctrl_state_t;

endpackage

// File: rtl/rx_mem_ctrl_if.sv
// Receiver / DMA / buffer-write signal bundle around rx_mem_ctrl.
interface rx_mem_ctrl_if
  import dma_pkg::*;
#(
  parameter int unsigned WIDTH = DmaWidth
);

  logic             cfg_en;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             rx_eof;
  logic             dma_ack;
  logic             clr_ovf;
  logic             mem_wr_en;
  logic [WIDTH-1:0] rx_mem_addr;
  logic [WIDTH-1:0] data_rx_in;
  logic             frame_rdy;
  logic [WIDTH:0]   frame_len;
  logic             ovf_err;

  // Environment side: receiver, DMA engine and configuration.
  modport master (
    output cfg_en, rx_valid, rx_data, rx_eof, dma_ack, clr_ovf,
    input  mem_wr_en, rx_mem_addr, data_rx_in, frame_rdy, frame_len, ovf_err
  );

  // Controller side.
  modport slave (
    input  cfg_en, rx_valid, rx_data, rx_eof, dma_ack, clr_ovf,
    output mem_wr_en, rx_mem_addr, data_rx_in, frame_rdy, frame_len, ovf_err
  );

endinterface

// File: rtl/rx_wr_ptr.sv
// Write pointer / byte counter for one frame; last_o flags that the next write is the final slot.
module rx_wr_ptr
  import dma_pkg::*;
#(
  parameter int unsigned WIDTH = DmaWidth,
  parameter int unsigned DEPTH = DmaDepth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] ptr_o,
  output logic [WIDTH:0]   count_o,
  output logic             last_o
);

  // One extra bit so a full buffer of 2^WIDTH entries can be counted.
  logic [WIDTH:0] cnt_q, cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + (WIDTH+1)'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ptr_o   = cnt_q[WIDTH-1:0];
  assign count_o = cnt_q;
  // The write taking place now brings the count to DEPTH.
  assign last_o  = (cnt_q == (WIDTH+1)'(DEPTH - 1));

endmodule

// File: rtl/rx_mem_ctrl.sv
// Write-side controller for the DMA receive buffer: fills a frame, then holds it until dma_ack.
module rx_mem_ctrl
  import dma_pkg::*;
#(
  parameter int unsigned WIDTH = DmaWidth,
  parameter int unsigned DEPTH = DmaDepth
) (
  input  logic          clk,
  input  logic          rst_n,
  rx_mem_ctrl_if.slave  bus
);

  rx_ctrl_state_t state_q, state_d;

  logic             ptr_clr, ptr_inc, ptr_last;
  logic [WIDTH-1:0] ptr;
  logic [WIDTH:0]   count;
  logic             accept, end_frame;

  logic             mem_wr_en_q, mem_wr_en_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             frame_rdy_q, frame_rdy_d;
  logic [WIDTH:0]   frame_len_q, frame_len_d;
  logic             ovf_q, ovf_d;

  rx_wr_ptr #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (ptr_clr),
    .inc_i   (ptr_inc),
    .ptr_o   (ptr),
    .count_o (count),
    .last_o  (ptr_last)
  );

  // A byte is written only while enabled and not holding a finished frame.
  assign accept    = bus.rx_valid & bus.cfg_en & (state_q != HOLD);
  assign end_frame = accept & (bus.rx_eof | ptr_last);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = end_frame ? HOLD : FILL;
      FILL: begin
        if (!bus.cfg_en) begin
          state_d = IDLE;
        end else if (end_frame) begin
          state_d = HOLD;
        end
      end
      HOLD: if (bus.dma_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and pointer-control next values.
  always_comb begin
    ptr_inc     = accept;
    ptr_clr     = ((state_q == FILL) && !bus.cfg_en) || ((state_q == HOLD) && bus.dma_ack);
    mem_wr_en_d = accept;
    addr_d      = accept ? ptr : addr_q;
    data_d      = accept ? bus.rx_data : data_q;
    frame_rdy_d = (state_d == HOLD);
    frame_len_d = end_frame ? count + (WIDTH+1)'(1) : frame_len_q;
    // A drop in the same cycle as clr_ovf keeps the flag set.
    ovf_d       = ovf_q;
    if ((state_q == HOLD) && bus.rx_valid) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_wr_en_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      frame_rdy_q <= 1'b0;
      frame_len_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      mem_wr_en_q <= mem_wr_en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      frame_rdy_q <= frame_rdy_d;
      frame_len_q <= frame_len_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.rx_mem_addr = addr_q;
  assign bus.data_rx_in  = data_q;
  assign bus.frame_rdy   = frame_rdy_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.ovf_err     = ovf_q;

endmodule

// File: tb/tb_rx_mem_ctrl.sv
// Directed bench for rx_mem_ctrl with WIDTH=8, DEPTH=8.
module tb_rx_mem_ctrl;
  import dma_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned D = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rx_mem_ctrl_if #(.WIDTH(W)) bus ();

  rx_mem_ctrl #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic       rst_n;
    logic       en;
    logic       val;
    logic [7:0] data;
    logic       eof;
    logic       ack;
    logic       clr;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       rdy;
    logic [8:0] len;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(string n, logic r, logic e, logic v, logic [7:0] d, logic eo,
                              logic a, logic c, logic w, logic [7:0] ad, logic [7:0] wd,
                              logic rd, logic [8:0] l, logic o);
    vec_t t;
    t.name = n; t.rst_n = r; t.en = e; t.val = v; t.data = d; t.eof = eo; t.ack = a; t.clr = c;
    t.wr = w; t.addr = ad; t.wdata = wd; t.rdy = rd; t.len = l; t.ovf = o;
    vecs.push_back(t);
  endfunction

  task automatic drive(logic r, logic e, logic v, logic [7:0] d, logic eo, logic a, logic c);
    rst_n       = r;
    bus.cfg_en  = e;
    bus.rx_valid = v;
    bus.rx_data = d;
    bus.rx_eof  = eo;
    bus.dma_ack = a;
    bus.clr_ovf = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string n, logic w, logic [7:0] ad, logic [7:0] wd, logic rd,
                       logic [8:0] l, logic o);
    n_checks++;
    if ({bus.mem_wr_en, bus.rx_mem_addr, bus.data_rx_in, bus.frame_rdy, bus.frame_len,
         bus.ovf_err} !== {w, ad, wd, rd, l, o}) begin
      n_fail++;
      $display("FAIL %s: got wr=%b addr=%h data=%h rdy=%b len=%0d ovf=%b, want wr=%b addr=%h data=%h rdy=%b len=%0d ovf=%b",
               n, bus.mem_wr_en, bus.rx_mem_addr, bus.data_rx_in, bus.frame_rdy,
               bus.frame_len, bus.ovf_err, w, ad, wd, rd, l, o);
    end
  endtask

  initial begin
    //  name        rst en val data   eof ack clr | wr addr  data   rdy len ovf
    add("reset",     0, 0, 0, 8'h00, 0, 0, 0,   0, 8'h0, 8'h00, 0, 9'd0, 0);
    add("idle_nop",  1, 1, 0, 8'h00, 0, 0, 0,   0, 8'h0, 8'h00, 0, 9'd0, 0);
    add("short0",    1, 1, 1, 8'h11, 0, 0, 0,   1, 8'h0, 8'h11, 0, 9'd0, 0);
    add("short1",    1, 1, 1, 8'h22, 0, 0, 0,   1, 8'h1, 8'h22, 0, 9'd0, 0);
    add("short2",    1, 1, 1, 8'h33, 1, 0, 0,   1, 8'h2, 8'h33, 1, 9'd3, 0);
    add("short_hold",1, 1, 0, 8'h00, 0, 0, 0,   0, 8'h2, 8'h33, 1, 9'd3, 0);
    add("short_ack", 1, 1, 0, 8'h00, 0, 1, 0,   0, 8'h2, 8'h33, 0, 9'd3, 0);
    for (int i = 0; i < 8; i++) begin
      add($sformatf("full%0d", i), 1, 1, 1, 8'(8'hA0 + i), 0, 0, 0,
          1, i[7:0], 8'(8'hA0 + i), (i == 7), (i == 7) ? 9'd8 : 9'd3, 0);
    end
    add("drop9",     1, 1, 1, 8'hEE, 0, 0, 0,   0, 8'h7, 8'hA7, 1, 9'd8, 1);
    add("clr_race",  1, 1, 1, 8'hEF, 0, 0, 1,   0, 8'h7, 8'hA7, 1, 9'd8, 1);
    add("clr_lone",  1, 1, 0, 8'h00, 0, 0, 1,   0, 8'h7, 8'hA7, 1, 9'd8, 0);
    add("ack_drop",  1, 1, 1, 8'h12, 0, 1, 0,   0, 8'h7, 8'hA7, 0, 9'd8, 1);
    add("rel_55",    1, 1, 1, 8'h55, 0, 0, 0,   1, 8'h0, 8'h55, 0, 9'd8, 1);
    add("ab_61",     1, 1, 1, 8'h61, 0, 0, 0,   1, 8'h1, 8'h61, 0, 9'd8, 1);
    add("ab_62",     1, 1, 1, 8'h62, 0, 0, 0,   1, 8'h2, 8'h62, 0, 9'd8, 1);
    add("abort",     1, 0, 0, 8'h00, 0, 0, 0,   0, 8'h2, 8'h62, 0, 9'd8, 1);
    add("dis_drop",  1, 0, 1, 8'h66, 0, 0, 0,   0, 8'h2, 8'h62, 0, 9'd8, 1);
    add("re_77",     1, 1, 1, 8'h77, 0, 0, 0,   1, 8'h0, 8'h77, 0, 9'd8, 1);
    add("re_78",     1, 1, 1, 8'h78, 0, 0, 0,   1, 8'h1, 8'h78, 0, 9'd8, 1);
    add("mid_reset", 0, 1, 1, 8'h79, 0, 0, 0,   0, 8'h0, 8'h00, 0, 9'd0, 0);
    add("single_9c", 1, 1, 1, 8'h9C, 1, 0, 0,   1, 8'h0, 8'h9C, 1, 9'd1, 0);
    add("hold_dis",  1, 0, 0, 8'h00, 0, 0, 0,   0, 8'h0, 8'h9C, 1, 9'd1, 0);
    add("hold_drop", 1, 0, 1, 8'h44, 0, 0, 0,   0, 8'h0, 8'h9C, 1, 9'd1, 1);
    add("hold_clr",  1, 0, 0, 8'h00, 0, 0, 1,   0, 8'h0, 8'h9C, 1, 9'd1, 0);
    add("hold_ack",  1, 0, 0, 8'h00, 0, 1, 0,   0, 8'h0, 8'h9C, 0, 9'd1, 0);
    add("idle_ack",  1, 1, 0, 8'h00, 0, 1, 0,   0, 8'h0, 8'h9C, 0, 9'd1, 0);
    add("fa_a5",     1, 1, 1, 8'hA5, 0, 0, 0,   1, 8'h0, 8'hA5, 0, 9'd1, 0);
    add("fill_ack",  1, 1, 0, 8'h00, 0, 1, 0,   0, 8'h0, 8'hA5, 0, 9'd1, 0);
    add("fa_b6",     1, 1, 1, 8'hB6, 1, 0, 0,   1, 8'h1, 8'hB6, 1, 9'd2, 0);
    add("fa_rel",    1, 1, 0, 8'h00, 0, 1, 0,   0, 8'h1, 8'hB6, 0, 9'd2, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].val, vecs[i].data, vecs[i].eof, vecs[i].ack,
            vecs[i].clr);
      tick();
      check(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdy, vecs[i].len,
            vecs[i].ovf);
    end

    // Eof on the DEPTH-th byte yields one frame of length DEPTH.
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 1, 8'(8'hC0 + i), (i == 7), 0, 0);
      tick();
      check($sformatf("eof_full%0d", i), 1, i[7:0], 8'(8'hC0 + i), (i == 7),
            (i == 7) ? 9'd8 : 9'd2, 0);
    end
    drive(1, 1, 0, 8'h00, 0, 0, 0);
    tick();
    check("eof_full_hold", 0, 8'h7, 8'hC7, 1, 9'd8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_mem_ctrl.md
# rx_mem_ctrl

Write-side controller for the DMA receive buffer memory. It accepts bytes from the UART/serial receiver through a valid strobe. It sequences them into consecutive buffer addresses and detects end-of-frame or buffer-full. It then holds the completed frame for the DMA read engine until that engine acknowledges. It owns the buffer's write enable, write address and write data; nothing else writes the buffer.

## Interface
- WIDTH, 8, data width of one buffer entry and of the address bus
- DEPTH, 8, number of buffer entries; legal range 2..2^WIDTH
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- cfg_en  in  1  block enable; 0 forces IDLE behaviour (no writes)
- rx_valid  in  1  one-cycle strobe, rx_data is a received byte
- rx_data  in  WIDTH  received byte
- rx_eof  in  1  qualifies rx_valid: this byte is the last of the frame
- dma_ack  in  1  one-cycle pulse, DMA has drained the frame
- clr_ovf  in  1  one-cycle pulse, clears ovf_err
- mem_wr_en  out  1  buffer write enable
- rx_mem_addr  out  WIDTH  buffer write address
- data_rx_in  out  WIDTH  buffer write data
- frame_rdy  out  1  level, a complete frame is in the buffer
- frame_len  out  WIDTH+1  bytes in the ready frame (1..DEPTH)
- ovf_err  out  1  sticky, a byte was dropped

## Operation
- States: IDLE, FILL, HOLD.
- IDLE: wr_ptr=0, count=0. On rx_valid&cfg_en, write the byte at address 0 and go to FILL. Go to HOLD instead if rx_eof=1 or DEPTH==1.
- FILL: each rx_valid writes at wr_ptr, then wr_ptr++ and count++.
  - If rx_eof=1 or count reaches DEPTH, latch frame_len=count and go to HOLD.
- HOLD: frame_rdy=1 and frame_len is stable. Any rx_valid is dropped and sets ovf_err, with no write.
  - dma_ack returns the block to IDLE with wr_ptr=0. dma_ack outside HOLD is ignored.
- cfg_en=0 in FILL aborts the partial frame: return to IDLE and discard count.
- cfg_en=0 in HOLD has no effect; the frame is kept until dma_ack.
- Address arithmetic: wr_ptr counts 0..DEPTH-1 and never wraps within a frame. Reaching DEPTH always ends the frame.
- ovf_err: set by a dropped byte; cleared by clr_ovf. If both occur in the same cycle, set wins.
- Simultaneous events:
  - rx_valid with dma_ack in HOLD: the byte is dropped (ovf set), then IDLE.
  - rx_valid with rx_eof on the DEPTH-th byte: a single frame of length DEPTH.

## Timing
- All outputs are registered. Reset values: mem_wr_en=0, rx_mem_addr=0, data_rx_in=0, frame_rdy=0, frame_len=0, ovf_err=0, state=IDLE.
- rx_valid at cycle N produces mem_wr_en=1 at N+1, with the address and data of that byte. mem_wr_en is a single-cycle pulse per byte.
- The last byte's write (N+1) and frame_rdy=1 (N+1) coincide, so the memory holds the byte at N+2. DMA reads must therefore start no earlier than one cycle after frame_rdy rises; the DMA engine's read latency guarantees this.
- dma_ack at cycle M drops frame_rdy at M+1. A new frame's first byte is accepted from rx_valid at M+1.
- Back-to-back rx_valid every cycle is supported at full rate.
- rst_n low for one clk edge returns everything to reset values, including mid-frame. The buffer contents are not cleared.

## Structure
- Shared package dma_pkg: state enum rx_ctrl_state_t {IDLE, FILL, HOLD}; default WIDTH/DEPTH constants shared with the buffer and the DMA read engine.
- One sub-module is natural: rx_wr_ptr. It holds the address/count register with clear, increment and terminal-count (==DEPTH) flag. The FSM and output registers stay in rx_mem_ctrl.
- The buffer memory is instantiated beside this block at the DMA top, not inside it.

## Test plan
- Short frame: bytes 0x11,0x22,0x33 (eof on 0x33), DEPTH=8 -> writes at addr 0,1,2, one cycle after each strobe. frame_rdy=1 and frame_len=3 in the cycle of the 0x33 write.
- Full buffer: 8 back-to-back bytes 0xA0..0xA7 with no eof -> addresses 0..7, frame_len=8, HOLD. A 9th byte sets ovf_err=1 and produces no write.
- Release: in HOLD, pulse dma_ack, then send 0x55 the next cycle -> frame_rdy=0, 0x55 written at addr 0.
- Overflow clear race: clr_ovf and a dropped rx_valid in the same HOLD cycle -> ovf_err stays 1. A lone clr_ovf later gives ovf_err=0.
- Abort and reset: after 3 bytes in FILL, drop cfg_en -> IDLE. Re-enable and send 0x77 -> it is written at addr 0. Separately, rst_n low mid-FILL -> all outputs at reset values on the next cycle.
- Single-byte eof: one byte 0x9C with rx_eof in IDLE -> write at addr 0, frame_len=1, HOLD.
